adaptive_traffic_ctrl_n: RTL

ADAPTIVE_TRAFFIC_CTRL_N -- requirements
Module: adaptive_traffic_ctrl_n

---
 rtl/adaptive_traffic_ctrl_n.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/adaptive_traffic_ctrl_n.sv
// adaptive_traffic_ctrl_n: N-way adaptive traffic light sequencer.
// The sequence runs GREEN -> ORANGE -> ALLRED -> GREEN (next direction). A green
// phase is re-armed while its own direction carries strictly the most traffic.
// Optional build macro: ATC_MAX_GREEN_EN caps consecutive green re-arms at MAX_EXT.
//
// state     | meaning
// ----------+----------------------------------------------------------
// PH_GREEN  | active_dir shows green, others red; may re-arm on dominance
// PH_ORANGE | active_dir shows orange, others red
// PH_ALLRED | every lamp red (clearance) before the next green is chosen
module adaptive_traffic_ctrl_n #(
    parameter int N_DIR    = 4,
    parameter int SW       = 2,
    parameter int GREEN_T  = 30,
    parameter int ORANGE_T = 3,
    parameter int ALLRED_T = 1,
    parameter int MAX_EXT  = 3,
    localparam int DW      = (N_DIR > 1) ? $clog2(N_DIR) : 1,
    localparam int MAX_GO  = (GREEN_T > ORANGE_T) ? GREEN_T : ORANGE_T,
    localparam int MAX_T   = (MAX_GO > ALLRED_T) ? MAX_GO : ALLRED_T,
    localparam int CW      = $clog2(MAX_T + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic [N_DIR*SW-1:0]  sensors,
    output logic [N_DIR*3-1:0]   lights,
    output logic [DW-1:0]        active_dir,
    output logic [1:0]           phase,
    output logic [CW-1:0]        remaining,
    output logic                 phase_start
);

    typedef enum logic [1:0] {
        PH_GREEN  = 2'b00,
        PH_ORANGE = 2'b01,
        PH_ALLRED = 2'b10
    } phase_t;

    localparam logic [CW-1:0] REM_ONE = CW'(1);

    if (N_DIR < 2 || N_DIR > 8 || SW < 1 || GREEN_T < 1 || ORANGE_T < 1 ||
        ALLRED_T < 1 || MAX_EXT < 0) begin : g_param_chk
        $error("adaptive_traffic_ctrl_n: parameter out of legal range");
    end

    phase_t               phase_q;
    logic [DW-1:0]        dir_q;
    logic [CW-1:0]        rem_q;
    logic                 start_q;
    logic [N_DIR*3-1:0]   lights_q;

    logic [DW-1:0]        next_dir_d;
    logic                 dominant_d;
    logic                 hold_d;

    // Lamp pattern for a given phase and owning direction.
    function automatic logic [N_DIR*3-1:0] lamps(phase_t ph, logic [DW-1:0] d);
        logic [N_DIR*3-1:0] l;
        l = '0;
        for (int i = 0; i < N_DIR; i++) begin
            if (ph != PH_ALLRED && d == DW'(i))
                l[i*3 +: 3] = (ph == PH_GREEN) ? 3'b001 : 3'b010;
            else
                l[i*3 +: 3] = 3'b100;
        end
        return l;
    endfunction

    // Scan the other directions starting at active_dir+1: strict '>' keeps the
    // first tied candidate (round-robin), and an all-zero field leaves active_dir+1.
    always_comb begin : sel_blk
        int            idx;
        logic [SW-1:0] own;
        logic [SW-1:0] cur;
        logic [SW-1:0] best;
        own        = sensors[int'(dir_q)*SW +: SW];
        dominant_d = 1'b1;
        idx        = int'(dir_q) + 1;
        if (idx >= N_DIR) idx = idx - N_DIR;
        next_dir_d = DW'(idx);
        best       = sensors[idx*SW +: SW];
        for (int k = 1; k < N_DIR; k++) begin
            idx = int'(dir_q) + k;
            if (idx >= N_DIR) idx = idx - N_DIR;
            cur = sensors[idx*SW +: SW];
            if (own <= cur) dominant_d = 1'b0;
            if (cur > best) begin
                best       = cur;
                next_dir_d = DW'(idx);
            end
        end
    end

`ifdef ATC_MAX_GREEN_EN
    localparam int EW = (MAX_EXT > 0) ? $clog2(MAX_EXT + 1) : 1;
    logic [EW-1:0] ext_q;

    // Green may only re-arm while the extension budget is not yet used up.
    always_comb begin
        hold_d = dominant_d && (ext_q < EW'(MAX_EXT));
    end

    // Extension counter: counts re-arms within one green, cleared on leaving it.
    always_ff @(posedge clk) begin
        if (rst)
            ext_q <= '0;
        else if (tick && rem_q == REM_ONE && phase_q == PH_GREEN)
            ext_q <= hold_d ? ext_q + EW'(1) : '0;
        else if (phase_q != PH_GREEN)
            ext_q <= '0;
    end
`else
    // Unlimited extensions: dominance alone re-arms the green.
    always_comb begin
        hold_d = dominant_d;
    end
`endif

    // Phase sequencer with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= PH_GREEN;
            dir_q    <= '0;
            rem_q    <= CW'(GREEN_T);
            start_q  <= 1'b0;
            lights_q <= lamps(PH_GREEN, '0);
        end else if (tick && rem_q == REM_ONE) begin
            case (phase_q)
                PH_GREEN: begin
                    if (hold_d) begin
                        rem_q   <= CW'(GREEN_T);
                        start_q <= 1'b0;
                    end else begin
                        phase_q  <= PH_ORANGE;
                        rem_q    <= CW'(ORANGE_T);
                        start_q  <= 1'b1;
                        lights_q <= lamps(PH_ORANGE, dir_q);
                    end
                end
                PH_ORANGE: begin
                    phase_q  <= PH_ALLRED;
                    rem_q    <= CW'(ALLRED_T);
                    start_q  <= 1'b1;
                    lights_q <= lamps(PH_ALLRED, dir_q);
                end
                PH_ALLRED: begin
                    phase_q  <= PH_GREEN;
                    dir_q    <= next_dir_d;
                    rem_q    <= CW'(GREEN_T);
                    start_q  <= 1'b1;
                    lights_q <= lamps(PH_GREEN, next_dir_d);
                end
                default: begin
                    phase_q  <= PH_ALLRED;
                    rem_q    <= CW'(ALLRED_T);
                    start_q  <= 1'b1;
                    lights_q <= lamps(PH_ALLRED, dir_q);
                end
            endcase
        end else begin
            if (tick) rem_q <= rem_q - REM_ONE;
            start_q <= 1'b0;
        end
    end

    assign lights      = lights_q;
    assign active_dir  = dir_q;
    assign phase       = phase_q;
    assign remaining   = rem_q;
    assign phase_start = start_q;

endmodule
